multi_cycle_cpu: RTL and testbench

//  Parametrised multi-cycle RV-subset core; successor to the single-cycle top level.

---
 rtl/multi_cycle_cpu.sv | 145 ++++++++++++++
 tb/tb_multi_cycle_cpu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle RV-subset core with a shared req/ack memory port.
// Each instruction walks FETCH/DECODE/EXECUTE/MEM/WB; illegal encodings park it in HALT.
module multi_cycle_cpu #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int DEBUG_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            retire,
    output logic            halted,
    output logic [XLEN-1:0] debug_out
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;
    localparam int SW = $clog2(XLEN);
    localparam logic [2:0] LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;
    logic [2:0] state;
    logic [31:0] ir;
    logic [XLEN-1:0] pc, a, b, imm, alu_out, mdr;
    logic [XLEN-1:0] regs [32];
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, legal, taken, go_fetch, rf_we;
    logic [XLEN-1:0] imm_dec, op_b, alu_res, fetch_pc, rf_wd;
    assign opcode = ir[6:0];
    assign rd = ir[11:7];
    assign f3 = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7 = ir[31:25];
    always_comb begin
        is_r = opcode == 7'h33;
        is_i = opcode == 7'h13;
        is_ld = opcode == 7'h03;
        is_st = opcode == 7'h23;
        is_br = opcode == 7'h63;
        is_jal = opcode == 7'h6f;
        legal = (is_r && f3 != 3'b011 && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000)))
             || (is_i && f3 == 3'b000) || ((is_ld || is_st) && f3 == LS_F3)
             || (is_br && f3[2:1] == 2'b00) || is_jal;
        imm_dec = is_st ? {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]}
                : is_br ? {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}
                : is_jal ? {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}
                : {{(XLEN-12){ir[31]}}, ir[31:20]};
        op_b = is_r ? b : imm;
        taken = f3[0] ? a != b : a == b;
        fetch_pc = (state == EXECUTE && (is_jal || (is_br && taken))) ? pc + imm : pc + XLEN'(4);
        go_fetch = (state == EXECUTE && (is_br || is_jal)) || (state == MEM && is_st && mem_ack) || state == WB;
        rf_we = state == WB || (state == EXECUTE && is_jal);
        rf_wd = state == WB ? (is_ld ? mdr : alu_out) : pc + XLEN'(4);
        alu_res = '0;
        case (f3)
            3'b000: alu_res = (is_r && f7[5]) ? a - op_b : a + op_b;
            3'b001: alu_res = a << b[SW-1:0];
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(op_b)};
            3'b100: alu_res = a ^ op_b;
            3'b101: alu_res = a >> b[SW-1:0];
            3'b110: alu_res = a | op_b;
            3'b111: alu_res = a & op_b;
            default: alu_res = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            retire <= 1'b0;
            halted <= 1'b0;
            debug_out <= '0;
            ir <= '0;
            a <= '0;
            b <= '0;
            imm <= '0;
            alu_out <= '0;
            mdr <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            if (rf_we && rd != 5'd0) regs[rd] <= rf_wd;
            if (rf_we && rd != 5'd0 && rd == 5'(DEBUG_REG)) debug_out <= rf_wd;
            case (state)
                FETCH: begin
                    // Only the first fetch after reset arrives here without a request already posted.
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                        mem_we <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        ir <= mem_rdata[31:0];
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a <= rs1 == 5'd0 ? '0 : regs[rs1];
                    b <= rs2 == 5'd0 ? '0 : regs[rs2];
                    imm <= imm_dec;
                    halted <= !legal;
                    state <= legal ? EXECUTE : HALT;
                end
                EXECUTE: begin
                    if (is_ld || is_st) begin
                        mem_req <= 1'b1;
                        mem_we <= is_st;
                        mem_addr <= a + imm;
                        mem_wdata <= b;
                        state <= MEM;
                    end else if (!is_br && !is_jal) begin
                        alu_out <= alu_res;
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we <= 1'b0;
                        mdr <= mem_rdata;
                        state <= WB;
                    end
                end
                default: ;
            endcase
            // Completing instructions post the next fetch immediately so it starts next cycle.
            if (go_fetch) begin
                pc <= fetch_pc;
                mem_req <= 1'b1;
                mem_we <= 1'b0;
                mem_addr <= fetch_pc;
                retire <= 1'b1;
                state <= FETCH;
            end
        end
    end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed program run against a req/ack memory model with configurable wait states.
module tb_multi_cycle_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_req, mem_we, mem_ack, retire, halted;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, debug_out;
    logic [31:0] mem32 [512];
    int n_chk = 0;
    int n_fail = 0;
    int delay = 0;
    int cnt = 0;
    logic [63:0] h_addr, h_wdata, wr_addr, wr_data;
    logic h_we;
    int exp_lat [19];
    logic [63:0] exp_dbg [19];
    logic [63:0] exp_nxt [19];

    multi_cycle_cpu #(.XLEN(64), .RESET_PC(64'h100), .DEBUG_REG(31)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .retire(retire), .halted(halted), .debug_out(debug_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
    endfunction

    // Memory responder: acks after 'delay' wait cycles and checks the request stays stable while stalled.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else begin
            if (cnt == 0) begin
                h_addr = mem_addr;
                h_we = mem_we;
                h_wdata = mem_wdata;
            end else begin
                check("hold_addr", mem_addr, h_addr);
                check("hold_we", {63'd0, mem_we}, {63'd0, h_we});
                check("hold_wdata", mem_wdata, h_wdata);
            end
            if (cnt == delay) begin
                mem_ack = 1'b1;
                mem_rdata = {mem32[int'(mem_addr[9:2]) + 1], mem32[int'(mem_addr[9:2])]};
                if (mem_we) begin
                    mem32[int'(mem_addr[9:2])] = mem_wdata[31:0];
                    mem32[int'(mem_addr[9:2]) + 1] = mem_wdata[63:32];
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end
                cnt = 0;
            end else begin
                mem_ack = 1'b0;
                cnt++;
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {63'd0, mem_req}, 64'd0);
        check("rst_we", {63'd0, mem_we}, 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_debug", debug_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {63'd0, mem_req}, 64'd1);
        check("first_addr", mem_addr, 64'h100);
        check("first_we", {63'd0, mem_we}, 64'd0);
    endtask

    task automatic wait_retire(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!retire && n < 40);
        if (!retire) check("retire_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_step(input int k, input int lat);
        int n;
        wait_retire(n);
        check($sformatf("lat_%0d", k), 64'(n), 64'(lat));
        check($sformatf("dbg_%0d", k), debug_out, exp_dbg[k]);
        check($sformatf("next_%0d", k), mem_addr, exp_nxt[k]);
    endtask

    initial begin
        int n;
        int reqs;
        for (int i = 0; i < 512; i++) mem32[i] = 32'h0;
        mem32[64] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        mem32[65] = enc_i(12'hffd, 5'd0, 3'd0, 5'd2, 7'h13);
        mem32[66] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd31);
        mem32[67] = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd31);
        mem32[68] = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd31);
        mem32[69] = enc_r(7'h00, 5'd1, 5'd1, 3'd1, 5'd31);
        mem32[70] = enc_r(7'h00, 5'd1, 5'd2, 3'd5, 5'd31);
        mem32[71] = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd31);
        mem32[72] = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd31);
        mem32[73] = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd31);
        mem32[74] = enc_i(12'h6f5, 5'd0, 3'd0, 5'd3, 7'h13);
        mem32[75] = enc_i(12'd5, 5'd0, 3'd0, 5'd4, 7'h13);
        mem32[76] = enc_r(7'h00, 5'd4, 5'd3, 3'd1, 5'd3);
        mem32[77] = enc_i(12'd13, 5'd3, 3'd0, 5'd1, 7'h13);
        mem32[78] = enc_s(12'd8, 5'd1, 5'd0, 3'd3);
        mem32[79] = enc_i(12'd8, 5'd0, 3'd3, 5'd31, 7'h03);
        mem32[80] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);
        mem32[81] = 32'hffff_ffff;
        mem32[82] = enc_b(13'd8, 5'd0, 5'd0, 3'd1);
        mem32[83] = enc_j(21'd8, 5'd31);
        mem32[84] = 32'hffff_ffff;
        mem32[85] = 32'hffff_ffff;
        exp_dbg = '{64'd0, 64'd0, 64'd2, 64'hffff_ffff_ffff_fff8, 64'd1, 64'ha0, 64'h07ff_ffff_ffff_ffff,
                    64'd5, 64'hffff_ffff_ffff_fffd, 64'hffff_ffff_ffff_fff8, 64'hffff_ffff_ffff_fff8,
                    64'hffff_ffff_ffff_fff8, 64'hffff_ffff_ffff_fff8, 64'hffff_ffff_ffff_fff8,
                    64'hffff_ffff_ffff_fff8, 64'hdead, 64'hdead, 64'hdead, 64'h150};
        for (int k = 0; k < 16; k++) exp_nxt[k] = 64'h104 + 64'(4 * k);
        exp_nxt[16] = 64'h148;
        exp_nxt[17] = 64'h14c;
        exp_nxt[18] = 64'h154;
        for (int k = 0; k < 19; k++) exp_lat[k] = (k == 15) ? 5 : (k >= 16) ? 3 : 4;

        // Zero-wait run of the whole program, ending in an illegal instruction.
        do_reset();
        for (int k = 0; k < 19; k++) begin
            run_step(k, exp_lat[k]);
            if (k == 14) begin
                check("sd_addr", wr_addr, 64'd8);
                check("sd_data", wr_data, 64'hdead);
            end
        end
        n = 0;
        while (!halted && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("halted", {63'd0, halted}, 64'd1);
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            reqs += int'(mem_req) + int'(retire) + int'(!halted);
        end
        check("halt_quiet", 64'(reqs), 64'd0);
        check("halt_addr", mem_addr, 64'h154);

        // Three wait cycles on every request stretch an ALU op to 7 cycles.
        delay = 3;
        do_reset();
        for (int k = 0; k < 3; k++) run_step(k, 7);

        // Reset while the next fetch is stalled.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_abandon_req", {63'd0, mem_req}, 64'd0);
        delay = 0;
        do_reset();
        for (int k = 0; k < 3; k++) run_step(k, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
